// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the RV32 multi-cycle controller.
// The ILLEGAL_TRAP_EN build option is used by multicycle_ctrl.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_decoder.sv
// Opcode classifier for the multi-cycle controller.
// Purely combinational; anything not R/I-type is flagged illegal.
module opcode_decoder
    import multicycle_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_rtype,
    output logic       is_itype,
    output logic       is_illegal
);

    assign is_rtype   = (opcode == OP_RTYPE);
    assign is_itype   = (opcode == OP_ITYPE);
    assign is_illegal = !(is_rtype || is_itype);

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/WB sequencer for the shared-ALU RV32 datapath.
// Define ILLEGAL_TRAP_EN to halt on illegal opcodes instead of skipping them.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      instr_i,
    input  logic             imem_ready_i,
    output logic             imem_req_o,
    output logic             IRWrite_o,
    output logic             PCWrite_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       ALUOp_o,
    output logic             RegWrite_o,
    output logic             busy_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o
);

    state_t            state;
    logic              cls_imm;
    logic [CNT_W-1:0]  instret;
    logic              is_rtype;
    logic              is_itype;
    logic              is_illegal;
    logic              unused_bits;

    assign unused_bits = ^{instr_i[31:12], is_rtype};

    opcode_decoder u_dec (
        .opcode     (instr_i[6:0]),
        .is_rtype   (is_rtype),
        .is_itype   (is_itype),
        .is_illegal (is_illegal)
    );

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            cls_imm   <= 1'b0;
            instret   <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE:
                    if (start_i) state <= S_FETCH;
                S_FETCH:
                    if (imem_ready_i) state <= S_DECODE;
                S_DECODE: begin
                    cls_imm <= is_itype;
                    if (is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                        illegal_q <= 1'b1;
                        state     <= S_HALT;
`else
                        // PC already advanced in FETCH; retire as a NOP
                        instret <= instret + CNT_W'(1);
                        state   <= start_i ? S_FETCH : S_IDLE;
`endif
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC:
                    state <= S_WB;
                S_WB: begin
                    instret <= instret + CNT_W'(1);
                    state   <= start_i ? S_FETCH : S_IDLE;
                end
                S_HALT:
                    state <= S_HALT;
                default:
                    state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req_o = 1'b0;
        IRWrite_o  = 1'b0;
        PCWrite_o  = 1'b0;
        ALUSrcA_o  = 1'b0;
        ALUSrcB_o  = SRCB_RS2;
        ALUOp_o    = ALUOP_ADD;
        RegWrite_o = 1'b0;
        busy_o     = (state != S_IDLE);
        case (state)
            S_FETCH: begin
                imem_req_o = 1'b1;
                IRWrite_o  = imem_ready_i;
                PCWrite_o  = imem_ready_i;
                ALUSrcB_o  = SRCB_FOUR;
            end
            S_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = cls_imm ? SRCB_IMM : SRCB_RS2;
                ALUOp_o   = ALUOP_FUNCT;
            end
            S_WB: begin
                ALUSrcA_o  = 1'b1;
                ALUSrcB_o  = cls_imm ? SRCB_IMM : SRCB_RS2;
                ALUOp_o    = ALUOP_FUNCT;
                // x0 is hardwired; never write it
                RegWrite_o = (instr_i[11:7] != 5'd0);
            end
            default: ;
        endcase
    end

    assign instret_o = instret;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl (CNT_W = 4).
// Works with ILLEGAL_TRAP_EN either defined or undefined.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       req;
        logic       irw;
        logic       pcw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       regw;
        logic       busy;
        logic       ill;
        logic [3:0] cnt;
    } exp_t;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_ADDI5 = 32'h00700293;
    localparam logic [31:0] I_NOP   = 32'h00000013;
    localparam logic [31:0] I_ADDI1 = 32'h00108093;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] instr_i;
    logic        imem_ready_i;
    logic        imem_req_o;
    logic        IRWrite_o;
    logic        PCWrite_o;
    logic        ALUSrcA_o;
    logic [1:0]  ALUSrcB_o;
    logic [1:0]  ALUOp_o;
    logic        RegWrite_o;
    logic        busy_o;
    logic        illegal_o;
    logic [3:0]  instret_o;

    exp_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;
    logic [3:0] cnt;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .instr_i      (instr_i),
        .imem_ready_i (imem_ready_i),
        .imem_req_o   (imem_req_o),
        .IRWrite_o    (IRWrite_o),
        .PCWrite_o    (PCWrite_o),
        .ALUSrcA_o    (ALUSrcA_o),
        .ALUSrcB_o    (ALUSrcB_o),
        .ALUOp_o      (ALUOp_o),
        .RegWrite_o   (RegWrite_o),
        .busy_o       (busy_o),
        .illegal_o    (illegal_o),
        .instret_o    (instret_o)
    );

    function automatic exp_t ex_idle(input logic [3:0] c);
        return '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, c};
    endfunction
    function automatic exp_t ex_fetch(input logic r, input logic [3:0] c);
        return '{1'b1, r, r, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, c};
    endfunction
    function automatic exp_t ex_dec(input logic [3:0] c);
        return '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, c};
    endfunction
    function automatic exp_t ex_exec(input logic [1:0] b, input logic [3:0] c);
        return '{1'b0, 1'b0, 1'b0, 1'b1, b, 2'b10, 1'b0, 1'b1, 1'b0, c};
    endfunction
    function automatic exp_t ex_wb(input logic [1:0] b, input logic w,
                                   input logic [3:0] c);
        return '{1'b0, 1'b0, 1'b0, 1'b1, b, 2'b10, w, 1'b1, 1'b0, c};
    endfunction
    function automatic exp_t ex_halt(input logic [3:0] c);
        return '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, c};
    endfunction

    // Drive one cycle's inputs and queue the outputs expected in that cycle
    task automatic step(input logic s, input logic r, input logic [31:0] ins,
                        input exp_t e, input string tag);
        @(posedge clk);
        #1;
        rst_i        = 1'b0;
        start_i      = s;
        imem_ready_i = r;
        instr_i      = ins;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic rst_mid(input logic r, input exp_t e, input string tag);
        @(posedge clk);
        #1;
        start_i      = 1'b1;
        imem_ready_i = r;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic run(input logic [31:0] ins, input int waits,
                       input logic [1:0] b, input logic w,
                       input logic s_ex, input logic s_wb, input string tag);
        for (int i = 0; i < waits; i++)
            step(1'b1, 1'b0, ins, ex_fetch(1'b0, cnt), {tag, "_wait"});
        step(1'b1, 1'b1, ins, ex_fetch(1'b1, cnt), {tag, "_fetch"});
        step(1'b1, 1'b0, ins, ex_dec(cnt), {tag, "_dec"});
        step(s_ex, 1'b1, ins, ex_exec(b, cnt), {tag, "_exec"});
        step(s_wb, 1'b1, ins, ex_wb(b, w, cnt), {tag, "_wb"});
        cnt = cnt + 4'd1;
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  a;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = exp_t'({imem_req_o, IRWrite_o, PCWrite_o, ALUSrcA_o,
                            ALUSrcB_o, ALUOp_o, RegWrite_o, busy_o,
                            illegal_o, instret_o});
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", t, a, e);
                end
            end
        end
    end

    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        imem_ready_i = 1'b0;
        instr_i      = 32'h0;
        cnt          = 4'd0;
        exp_q.push_back(ex_idle(4'd0));
        tag_q.push_back("reset");
        @(negedge clk);

        step(1'b1, 1'b0, I_ADD, ex_idle(cnt), "idle_start");
        run(I_ADD, 0, 2'b00, 1'b1, 1'b1, 1'b0, "add");
        step(1'b1, 1'b0, I_ADDI5, ex_idle(4'd1), "idle_after_add");
        run(I_ADDI5, 3, 2'b10, 1'b1, 1'b1, 1'b1, "addi5");
        run(I_NOP, 0, 2'b10, 1'b0, 1'b1, 1'b0, "nop");
        step(1'b1, 1'b0, I_ADD, ex_idle(4'd3), "idle_after_nop");
        run(I_ADD, 0, 2'b00, 1'b1, 1'b0, 1'b0, "drop_exec");
        step(1'b0, 1'b0, I_ADD, ex_idle(4'd4), "idle_dropped");
        step(1'b1, 1'b0, I_ILL, ex_idle(4'd4), "idle_stay");
        step(1'b1, 1'b1, I_ILL, ex_fetch(1'b1, cnt), "ill_fetch");
`ifdef ILLEGAL_TRAP_EN
        step(1'b1, 1'b1, I_ILL, ex_dec(cnt), "ill_dec");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, I_ILL, ex_halt(4'd4), "ill_halt");
        rst_mid(1'b1, ex_idle(4'd0), "halt_reset");
        cnt = 4'd0;
        step(1'b1, 1'b0, I_ADD, ex_idle(cnt), "idle_after_halt");
        step(1'b1, 1'b0, I_ADD, ex_fetch(1'b0, cnt), "fetch_before_rst");
`else
        step(1'b1, 1'b1, I_ILL, ex_dec(cnt), "ill_dec");
        cnt = cnt + 4'd1;
        step(1'b1, 1'b0, I_ADD, ex_fetch(1'b0, 4'd5), "ill_refetch");
`endif
        rst_mid(1'b1, ex_idle(4'd0), "fetch_reset");
        cnt = 4'd0;
        step(1'b1, 1'b0, I_ADDI1, ex_idle(4'd0), "idle_after_rst");
        for (int i = 0; i < 16; i++)
            run(I_ADDI1, 0, 2'b10, 1'b1, 1'b1, (i != 15), "wrap");
        step(1'b0, 1'b0, I_ADDI1, ex_idle(4'd0), "wrapped");
        step(1'b0, 1'b0, I_ADDI1, ex_idle(4'd0), "idle_hold");

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32 datapath: it lets a single ALU compute both PC+4 and the instruction result, replacing single-cycle combinational control. It drives the PC, instruction register, register-file write enable, ALU operand muxes and ALUOp through a FETCH/DECODE/EXEC/WB state machine, handshakes with instruction memory, and counts retired instructions.

## Interface
- CNT_W, 32: width of the retired-instruction counter.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  run enable, sampled in IDLE and at the end of WB.
- instr_i  input  32  current instruction register contents.
- imem_ready_i  input  1  instruction memory has valid data this cycle.
- imem_req_o  output  1  fetch request.
- IRWrite_o  output  1  load the instruction register.
- PCWrite_o  output  1  load PC from the ALU result.
- ALUSrcA_o  output  1  ALU operand A select: 0 = PC, 1 = rs1.
- ALUSrcB_o  output  2  ALU operand B select: 00 = rs2, 01 = constant 4, 10 = sign-extended imm.
- ALUOp_o  output  2  00 = add, 10 = decode funct fields.
- RegWrite_o  output  1  register-file write enable.
- busy_o  output  1  high in every state except IDLE.
- illegal_o  output  1  sticky illegal-opcode flag.
- instret_o  output  CNT_W  count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- Every output not listed for a state is 0 in that state.
- IDLE:
  - All outputs 0, except instret_o and illegal_o, which hold their values.
  - start_i = 1 → FETCH.
- FETCH:
  - imem_req_o = 1; ALUSrcA_o = 0, ALUSrcB_o = 01, ALUOp_o = 00.
  - In the cycle imem_ready_i = 1: IRWrite_o = 1, PCWrite_o = 1, then → DECODE.
  - Otherwise stay in FETCH, with IRWrite_o and PCWrite_o at 0.
  - There is no timeout.
- DECODE: classify instr_i[6:0].
  - 0110011 (R-type) → EXEC.
  - 0010011 (I-type) → EXEC.
  - Any other opcode is illegal; see Configuration.
- EXEC:
  - ALUSrcA_o = 1, ALUOp_o = 10.
  - ALUSrcB_o = 00 for R-type, 10 for I-type.
  - Opcode class is latched in DECODE; the state always advances to WB.
- WB:
  - Same ALU selects as EXEC.
  - RegWrite_o = 1 unless instr_i[11:7] == 0.
  - instret_o increments by 1 in either case.
  - start_i = 1 → FETCH; start_i = 0 → IDLE.
- HALT: busy_o = 1, no control asserted; only reset exits.

## Timing
- Reset: state = IDLE, instret_o = 0, illegal_o = 0, all other outputs 0. Reset takes effect immediately (asynchronous), including in the middle of an instruction.
- Outputs are decoded from the registered state and the latched opcode class; imem_ready_i only gates IRWrite_o and PCWrite_o combinationally in FETCH.
- Latency with zero memory wait:
  - 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
  - The first FETCH is the cycle after start_i is sampled high in IDLE.
  - Each wait cycle with imem_ready_i = 0 adds exactly 1 cycle.
- start_i dropping mid-instruction has no effect until WB; the instruction always completes and retires.
- instret_o wraps from 2^CNT_W−1 to 0, with no flag.
- imem_ready_i outside FETCH is ignored.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An illegal opcode in DECODE sets illegal_o = 1 from the next cycle and goes to HALT.
  - The instruction is not retired.
- ILLEGAL_TRAP_EN undefined:
  - An illegal opcode is a NOP: DECODE goes to FETCH if start_i = 1, else to IDLE.
  - PC is already advanced; instret_o still increments.
  - illegal_o is tied to 0 and the HALT state is unreachable.

## Structure
- Package multicycle_pkg holds:
  - the state enum;
  - opcode constants OP_RTYPE and OP_ITYPE;
  - ALUSrcB encodings SRCB_RS2, SRCB_FOUR, SRCB_IMM;
  - ALUOp encodings ALUOP_ADD, ALUOP_FUNCT.
- One sub-module, opcode_decoder: combinational, takes instr_i[6:0] and returns {is_rtype, is_itype, is_illegal}.

## Test plan
- Reset, then start_i = 1 with imem_ready_i tied to 1 and instruction add x3,x1,x2 (0x002081B3) → state sequence FETCH, DECODE, EXEC (ALUSrcB_o = 00), WB with RegWrite_o = 1; instret_o = 1 after WB.
- addi x5,x0,7 (0x00700293) with imem_ready_i low for 3 FETCH cycles → imem_req_o held for 4 cycles, IRWrite_o and PCWrite_o pulse exactly once, ALUSrcB_o = 10 in EXEC; 7 cycles to retire.
- addi x0,x0,0 (0x00000013) → RegWrite_o stays 0 in WB; instret_o still increments.
- Opcode 0x7F:
  - with ILLEGAL_TRAP_EN: illegal_o = 1, state HALT, busy_o = 1, instret_o unchanged, and start_i has no effect;
  - without it: the machine is back in FETCH 2 cycles after FETCH completes, and instret_o increments.
- start_i dropped during EXEC → WB still writes, then IDLE with busy_o = 0; rst_i asserted during FETCH → all outputs 0 immediately, instret_o = 0.
- CNT_W = 4, 16 back-to-back retires → instret_o wraps from 15 to 0.
